sha256_block_core: RTL and testbench
====================================

Name: sha256_block_core

Overview:
- Single-block SHA-256 compression engine (FIPS 180-4). Takes a 256-bit chaining value and a padded 512-bit message block, and returns the updated 256-bit chaining value.
- Iterative datapath: one round per clock, 64 rounds per block.
- Sits under a message/padding controller that chains blocks. The first block is seeded from the constant IV module sha256_h0.

Parameters:
- None. Word size 32, rounds 64, block 512 bits are fixed.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-low (0 = in reset).
- H_in  input  256  chaining value in. Word H0 = [255:224] … H7 = [31:0].
- M_in  input  512  padded message block. W0 = [511:480] … W15 = [31:0], big-endian words.
- input_valid  input  1  start strobe; sampled only when idle.
- H_out  output  256  result chaining value, same packing as H_in.
- output_valid  output  1  one-cycle strobe marking H_out as new.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state → IDLE, round counter → 0, output_valid → 0, H_out → 0.
  - Working registers are cleared.
  - Reset overrides everything, including mid-block; a block in progress is abandoned and produces no output_valid.
- IDLE: on the edge E0 where input_valid=1:
  - Capture H_in into a saved chaining register.
  - Load a..h = H_in.
  - Load the 16-word schedule window = M_in.
  - Counter = 0; go to BUSY.
- BUSY: edges E1..E64 each perform round t = 0..63, using the standard formulas:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - Rotate: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - All additions are mod 2^32.
- Message schedule:
  - W[t] for t<16 comes from the window.
  - For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed in a 16-word sliding shift register. One new word per round.
- Completion: on E64, together with round 63:
  - H_out ← saved H + final a..h, word-wise mod 2^32.
  - output_valid ← 1; state → IDLE.
- Latency: output_valid is high during the cycle after E64, i.e. exactly 64 edges after the sampling edge. It drops at E65 unless re-triggered.
- H_out holds its value until the next completion or reset.
- input_valid while BUSY is ignored; no queuing.
- input_valid held high continuously: a new block starts at E64's following idle edge E65. Blocks are back-to-back with a one-cycle idle gap, and each block produces one strobe.
- H_in/M_in only need to be stable at the sampling edge.
- Next-block chaining: the controller feeds H_out back as H_in. No internal chaining beyond one block.

Decomposition:
- Package sha256_pkg holds:
  - K[0..63] round-constant table.
  - 256-bit IV constant (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - Functions Σ0, Σ1, σ0, σ1, Ch, Maj.
  - State enum {IDLE, BUSY}.
- Sub-module sha256_h0:
  - Single output H_0 [255:0] = IV constant; purely combinational; no clock/reset.
  - Benches and controllers instantiate it to seed H_in.

Test Plan:
- Reset check: hold rst=0 for 3 edges with input_valid=1 → output_valid stays 0, H_out=0, no block starts. Release rst=1 → engine is IDLE.
- "abc": H_in=IV, M_in = 61626380 00…00 00000018 (512 bits), one-cycle input_valid → output_valid exactly 64 edges later, H_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: H_in=IV, M_in = 80000000 followed by zeros → H_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdef…nopq" (length 0x1C0):
  - Block A = upper 512 bits, with H_in=IV.
  - Then feed H_out as H_in for block B.
  - Final H_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Busy protection: pulse input_valid again at round 10 with a different M_in → ignored; "abc" result unchanged, single strobe.
- Mid-block reset: assert rst=0 at round 30 → no output_valid, H_out=0. After release, a fresh "abc" block gives the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round helper functions and engine state type.
package sha256_pkg;

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_h0.sv
// Constant SHA-256 initial hash value, used to seed the first block of a message.
module sha256_h0
    import sha256_pkg::*;
(
    output logic [255:0] H_0
);

    assign H_0 = IV;

endmodule

// File: rtl/sha256_block_core.sv
// Iterative single-block SHA-256 compression: one round per clock, 64 rounds per block.
module sha256_block_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] H_in,
    input  logic [511:0] M_in,
    input  logic         input_valid,
    output logic [255:0] H_out,
    output logic         output_valid
);

    state_e       state_q, state_d;
    logic [5:0]   round_q, round_d;
    logic [31:0]  work_q  [8];  // a..h, index 0 is a
    logic [31:0]  work_d  [8];
    logic [31:0]  saved_q [8];  // chaining value the block started from
    logic [31:0]  saved_d [8];
    logic [31:0]  win_q   [16]; // win_q[0] is W[t] for the current round
    logic [31:0]  win_d   [16];
    logic [255:0] hout_q, hout_d;
    logic         valid_q, valid_d;

    logic [31:0]  t1, t2, w_new;
    logic [31:0]  rot [8];

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            round_q <= '0;
            hout_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                work_q[i]  <= '0;
                saved_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            hout_q  <= hout_d;
            valid_q <= valid_d;
            for (int i = 0; i < 8; i++) begin
                work_q[i]  <= work_d[i];
                saved_q[i] <= saved_d[i];
            end
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Round datapath: compression step and next schedule word for the current round.
    always_comb begin
        t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
             + K[round_q] + win_q[0];
        t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
        // Window holds W[t..t+15]; this yields W[t+16].
        w_new = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
        rot[0] = t1 + t2;
        rot[1] = work_q[0];
        rot[2] = work_q[1];
        rot[3] = work_q[2];
        rot[4] = work_q[3] + t1;
        rot[5] = work_q[4];
        rot[6] = work_q[5];
        rot[7] = work_q[6];
    end

    // Next-state logic: block load in idle, round iteration and final feed-forward when busy.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        hout_d  = hout_q;
        valid_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            work_d[i]  = work_q[i];
            saved_d[i] = saved_q[i];
        end
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (input_valid) begin
                    for (int i = 0; i < 8; i++) begin
                        work_d[i]  = H_in[32*(7-i) +: 32];
                        saved_d[i] = H_in[32*(7-i) +: 32];
                    end
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = M_in[32*(15-i) +: 32];
                    end
                    round_d = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int i = 0; i < 8; i++) begin
                    work_d[i] = rot[i];
                end
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[15] = w_new;
                round_d   = round_q + 6'd1;
                if (round_q == 6'd63) begin
                    for (int i = 0; i < 8; i++) begin
                        hout_d[32*(7-i) +: 32] = saved_q[i] + rot[i];
                    end
                    valid_d = 1'b1;
                    round_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign H_out        = hout_q;
    assign output_valid = valid_q;

endmodule

// File: tb/tb_sha256_block_core.sv
// Directed self-checking bench for sha256_block_core using known SHA-256 digests.
module tb_sha256_block_core;

    logic         clk;
    logic         rst;
    logic [255:0] H_in;
    logic [511:0] M_in;
    logic         input_valid;
    logic [255:0] H_out;
    logic         output_valid;
    logic [255:0] iv;

    int n_cmp;
    int n_err;

    localparam logic [511:0] MsgAbc   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] MsgEmpty = {32'h80000000, 480'h0};
    localparam logic [511:0] MsgTwoA  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] MsgTwoB  = {448'h0, 32'h00000000, 32'h000001c0};

    localparam logic [255:0] IvExp  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DigAbc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DigEmp = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DigTwo = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    sha256_h0 u_h0 (
        .H_0 (iv)
    );

    sha256_block_core u_dut (
        .clk          (clk),
        .rst          (rst),
        .H_in         (H_in),
        .M_in         (M_in),
        .input_valid  (input_valid),
        .H_out        (H_out),
        .output_valid (output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle start pulse; returns just after the sampling edge E0.
    task automatic start_block(input logic [255:0] h, input logic [511:0] m);
        @(negedge clk);
        H_in        = h;
        M_in        = m;
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        H_in        = '0;
        M_in        = '0;
    endtask

    // Edges until output_valid is seen (sampled #1 after each edge); -1 if the bound expires.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (output_valid) begin
                n = i;
                break;
            end
        end
    endtask

    // Counts strobes over a window of edges.
    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (output_valid) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic [255:0] mid;

        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        input_valid = 1'b1;
        H_in        = IvExp;
        M_in        = MsgAbc;

        check_eq("iv_const", iv, IvExp);

        // Reset held with input_valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_valid", {255'b0, output_valid}, 256'd0);
            check_eq("rst_hout", H_out, 256'd0);
        end
        @(negedge clk);
        rst         = 1'b1;
        input_valid = 1'b0;
        count_strobes(70, cnt);
        check_eq("rst_no_block", 256'(cnt), 256'd0);

        // "abc"
        start_block(iv, MsgAbc);
        wait_valid(n);
        check_eq("abc_latency", 256'(n), 256'd64);
        check_eq("abc_digest", H_out, DigAbc);
        @(posedge clk);
        #1;
        check_eq("abc_strobe_drop", {255'b0, output_valid}, 256'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("abc_hold", H_out, DigAbc);

        // Empty message
        start_block(iv, MsgEmpty);
        wait_valid(n);
        check_eq("empty_latency", 256'(n), 256'd64);
        check_eq("empty_digest", H_out, DigEmp);

        // Two-block message, chaining H_out back in
        start_block(iv, MsgTwoA);
        wait_valid(n);
        check_eq("two_a_latency", 256'(n), 256'd64);
        mid = H_out;
        start_block(mid, MsgTwoB);
        wait_valid(n);
        check_eq("two_b_latency", 256'(n), 256'd64);
        check_eq("two_digest", H_out, DigTwo);

        // Busy protection: second pulse sampled at E11 must be ignored
        start_block(iv, MsgAbc);
        repeat (10) @(posedge clk);
        start_block(iv, MsgEmpty);
        wait_valid(n);
        check_eq("busy_latency", 256'(n), 256'd53);
        check_eq("busy_digest", H_out, DigAbc);
        count_strobes(70, cnt);
        check_eq("busy_single", 256'(cnt), 256'd0);

        // input_valid held high: back-to-back blocks with a one-cycle idle gap
        @(negedge clk);
        H_in        = iv;
        M_in        = MsgEmpty;
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        wait_valid(n);
        check_eq("b2b_first", 256'(n), 256'd64);
        check_eq("b2b_first_dig", H_out, DigEmp);
        wait_valid(n);
        input_valid = 1'b0;
        check_eq("b2b_second", 256'(n), 256'd65);
        check_eq("b2b_second_dig", H_out, DigEmp);
        count_strobes(70, cnt);
        check_eq("b2b_stop", 256'(cnt), 256'd0);

        // Mid-block reset at round 30
        start_block(iv, MsgAbc);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_hout", H_out, 256'd0);
        check_eq("midrst_valid", {255'b0, output_valid}, 256'd0);
        @(negedge clk);
        rst = 1'b1;
        count_strobes(70, cnt);
        check_eq("midrst_no_strobe", 256'(cnt), 256'd0);
        check_eq("midrst_hout_kept", H_out, 256'd0);
        start_block(iv, MsgAbc);
        wait_valid(n);
        check_eq("post_rst_latency", 256'(n), 256'd64);
        check_eq("post_rst_digest", H_out, DigAbc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
